// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file with a per-register busy scoreboard. The decode
//   stage reads operands and locks destination registers; the writeback stage
//   writes results back through two write ports, which also clear the
//   matching busy bits.
//
// Parameters
//   XLEN      data width of each register
//   NREG      number of registers (power of two, >= 2)
//   NRD       number of read ports (1..4)
//   ZERO_REG  1 = register 0 reads as zero and ignores writes and locks
//   BYPASS    1 = same-cycle write data forwarded to matching reads
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   regwr0     write enable, port 0
//   rw0        write address, port 0
//   busw0      write data, port 0
//   regwr1     write enable, port 1 (higher priority)
//   rw1        write address, port 1
//   busw1      write data, port 1
//   ra         packed read addresses, port i at [i*AW +: AW]
//   bus        packed read data, port i at [i*XLEN +: XLEN] (combinational)
//   lock       mark register lock_addr busy
//   lock_addr  register to lock
//   busy_vec   registered busy bits, one per register
//   ra_busy    per-read-port busy indication (combinational)
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                regwr0,
    input  logic [AW-1:0]       rw0,
    input  logic [XLEN-1:0]     busw0,
    input  logic                regwr1,
    input  logic [AW-1:0]       rw1,
    input  logic [XLEN-1:0]     busw1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] bus,
    input  logic                lock,
    input  logic [AW-1:0]       lock_addr,
    output logic [NREG-1:0]     busy_vec,
    output logic [NRD-1:0]      ra_busy
);

    // True when the address targets the hardwired-zero register.
    function automatic logic is_zero_addr(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            we0_s;
    logic            we1_s;
    logic            lock_ok_s;
    logic [AW-1:0]   ra_s [NRD];

    // Qualified write/lock strobes: zero-register targets are dropped, and
    // nothing is accepted while reset is asserted (this also keeps the
    // bypass path from forwarding data during reset).
    always_comb begin
        we0_s     = rst & regwr0 & ~is_zero_addr(rw0);
        we1_s     = rst & regwr1 & ~is_zero_addr(rw1);
        lock_ok_s = rst & lock & ~is_zero_addr(lock_addr);
    end

    // Register storage; port 1 is assigned last so it wins on equal addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (we0_s) begin
                regs_r[rw0] <= busw0;
            end
            if (we1_s) begin
                regs_r[rw1] <= busw1;
            end
        end
    end

    // Scoreboard next state: a write clears, a lock sets; the lock is the
    // newer producer so it dominates a same-cycle write to the same register.
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            busy_nxt_s[i] = (lock_ok_s && (lock_addr == AW'(i))) |
                            (busy_r[i] & ~((we0_s && (rw0 == AW'(i))) ||
                                           (we1_s && (rw1 == AW'(i)))));
        end
        if (ZERO_REG != 0) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s[0] = busy_nxt_s[0];
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Unpack the read address bus into per-port addresses.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            ra_s[p] = ra[p*AW +: AW];
        end
    end

    // Read ports: zero register first, then forwarding (port 1 before
    // port 0), then the stored value. Forwarded reads are never busy since
    // the producer's data is already on the bus.
    always_comb begin
        bus     = {(NRD*XLEN){1'b0}};
        ra_busy = {NRD{1'b0}};
        for (int p = 0; p < NRD; p++) begin
            if (is_zero_addr(ra_s[p])) begin
                bus[p*XLEN +: XLEN] = {XLEN{1'b0}};
                ra_busy[p]          = 1'b0;
            end else if ((BYPASS != 0) && we1_s && (rw1 == ra_s[p])) begin
                bus[p*XLEN +: XLEN] = busw1;
                ra_busy[p]          = 1'b0;
            end else if ((BYPASS != 0) && we0_s && (rw0 == ra_s[p])) begin
                bus[p*XLEN +: XLEN] = busw0;
                ra_busy[p]          = 1'b0;
            end else begin
                bus[p*XLEN +: XLEN] = regs_r[ra_s[p]];
                ra_busy[p]          = busy_r[ra_s[p]];
            end
        end
    end

    assign busy_vec = busy_r;

endmodule
